// File: rtl/mux_pkg.sv
// Shared helpers for the round-robin registered mux: channel index width and
// packed-bus slice offsets.
package mux_pkg;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ch_off(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
// Rotates the doubled request vector down by ptr, then priority-encodes.
module rr_pick #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  logic [N_CH-1:0] rot;
  logic [CH_W:0]   off;
  logic [CH_W:0]   sum;
  logic            found;

  always_comb begin
    rot   = N_CH'({req, req} >> ptr);
    any   = |req;
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        off   = (CH_W+1)'(i);
      end
    end
    // Undo the rotation: absolute index = (ptr + off) mod N_CH
    sum = {1'b0, ptr} + off;
    if (sum >= (CH_W+1)'(N_CH)) sum = sum - (CH_W+1)'(N_CH);
    idx = sum[CH_W-1:0];
    gnt = '0;
    for (int i = 0; i < N_CH; i++) gnt[i] = any && (sum == (CH_W+1)'(i));
  end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel round-robin arbitrated mux into a single registered output slot.
// Define MUX_RR_ZERO_IDLE_EN to clear out_data/out_ch on idle load cycles.
module mux_rr_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_CH  = 4,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch
);

  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  rr_nxt;
  logic [CH_W:0]    nxt_w;
  logic [N_CH-1:0]  gnt;
  logic [CH_W-1:0]  idx;
  logic             any;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_pick (
    .req (in_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  // Slot is free when empty or being drained this cycle
  assign load     = !out_valid || out_ready;
  assign in_ready = load ? gnt : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++)
      if (gnt[i]) sel_data = in_data[ch_off(i, WIDTH) +: WIDTH];
    nxt_w = {1'b0, idx} + (CH_W+1)'(1);
    if (nxt_w >= (CH_W+1)'(N_CH)) nxt_w = '0;
    rr_nxt = nxt_w[CH_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= idx;
        rr_ptr    <= rr_nxt;
      end else begin
        out_valid <= 1'b0;
`ifdef MUX_RR_ZERO_IDLE_EN
        out_data  <= '0;
        out_ch    <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Bench for mux_rr_arb: directed plan checks plus randomized traffic scored
// against a queue-based round-robin reference model; also a 1-channel instance.
module tb_mux_rr_arb;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;

  logic [0:0]     s_in_valid, s_in_ready;
  logic [15:0]    s_in_data;
  logic           s_out_valid, s_out_ready;
  logic [15:0]    s_out_data;
  logic [0:0]     s_out_ch;

  mux_rr_arb #(.WIDTH(W), .N_CH(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch)
  );

  mux_rr_arb #(.WIDTH(16), .N_CH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_ch(s_out_ch)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   m_vld;
  int   m_ptr;

  // Reference model: evaluates each cycle's decision just before the edge
  always @(negedge clk) begin : model
    logic [N-1:0] rdy;
    bit           ld;
    int           g;
    if (!rst_n) begin
      m_vld = 0;
      m_ptr = 0;
      exp_q.delete();
    end else begin
      rdy = '0;
      ld  = !m_vld || out_ready;
      g   = -1;
      if (ld) begin
        for (int k = 0; k < N; k++)
          if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (g >= 0) begin
          rdy[g] = 1'b1;
          exp_q.push_back('{ch: 2'(g), data: in_data[g*W +: W]});
          m_ptr = (g + 1) % N;
          m_vld = 1;
        end else begin
          m_vld = 0;
        end
      end
      chk("in_ready", 32'(in_ready), 32'(rdy));
    end
  end

  // Monitor: pops the oldest expectation whenever the DUT hands off a word
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_empty: got data 0x%0h ch %0d want no output", out_data, out_ch);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(out_data), 32'(e.data));
        chk("sb_ch", 32'(out_ch), 32'(e.ch));
      end
    end
  end

  initial begin
    in_valid = '0; in_data = '0; out_ready = 1'b0;
    s_in_valid = '0; s_in_data = '0; s_out_ready = 1'b0;

    #12;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_ch", 32'(out_ch), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single channel
    in_valid = 4'b0100; in_data = 32'h00A5_0000; out_ready = 1'b1;
    #1 chk("single_rdy", 32'(in_ready), 32'h4);
    @(posedge clk); #1;
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_ch", 32'(out_ch), 32'h2);

    // Pointer is now 3: all-valid must grant channel 3 next
    in_valid = 4'hF; in_data = 32'h1312_1110;
    @(posedge clk); #1;
    chk("ptr3_ch", 32'(out_ch), 32'h3);
    chk("ptr3_data", 32'(out_data), 32'h13);

    // Reset mid-stream with a word held
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_data", 32'(out_data), 32'h0);
    chk("midrst_ch", 32'(out_ch), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Round-robin wrap
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("wrap_ch", 32'(out_ch), 32'(i % 4));
      chk("wrap_data", 32'(out_data), 32'(8'h10 + i % 4));
    end

    // Backpressure holding 0x11
    out_ready = 1'b0;
    repeat (3) begin
      #1 chk("bp_rdy", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk("bp_data", 32'(out_data), 32'h11);
      chk("bp_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_rdy", 32'(in_ready), 32'h4);
    @(posedge clk); #1;
    chk("bp_next_data", 32'(out_data), 32'h12);
    chk("bp_next_ch", 32'(out_ch), 32'h2);

    // Idle after a single transfer of 0x3C on channel 1
    in_valid = 4'b0010; in_data = 32'h0000_3C00;
    @(posedge clk); #1;
    chk("idle_pre_data", 32'(out_data), 32'h3C);
    chk("idle_pre_ch", 32'(out_ch), 32'h1);
    in_valid = '0;
    @(posedge clk); #1;
    chk("idle_valid", 32'(out_valid), 32'h0);
`ifdef MUX_RR_ZERO_IDLE_EN
    chk("idle_data", 32'(out_data), 32'h0);
    chk("idle_ch", 32'(out_ch), 32'h0);
`else
    chk("idle_data", 32'(out_data), 32'h3C);
    chk("idle_ch", 32'(out_ch), 32'h1);
`endif

    // Randomized traffic, scored by model/monitor
    repeat (3000) begin
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    // Drain
    in_valid = '0; out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("drain_q", 32'(exp_q.size()), 32'h0);
    chk("drain_valid", 32'(out_valid), 32'h0);

    // Single-channel pass-through, back-to-back words
    s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_data = 16'h1234;
    #1 chk("n1_rdy", 32'(s_in_ready), 32'h1);
    @(posedge clk); #1;
    s_in_data = 16'hBEEF;
    chk("n1_w0_valid", 32'(s_out_valid), 32'h1);
    chk("n1_w0_data", 32'(s_out_data), 32'h1234);
    chk("n1_w0_ch", 32'(s_out_ch), 32'h0);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    chk("n1_w1_valid", 32'(s_out_valid), 32'h1);
    chk("n1_w1_data", 32'(s_out_data), 32'hBEEF);
    chk("n1_w1_ch", 32'(s_out_ch), 32'h0);
    @(posedge clk); #1;
    chk("n1_idle_valid", 32'(s_out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
